// File: rtl/pico_pkg.sv
// Shared types and constants for the data-memory load/store unit.
package pico_pkg;

    localparam int unsigned D_WIDTH  = 8;
    localparam int unsigned A_WIDTH  = 8;
    localparam int unsigned RD_WIDTH = 3;

    // One queued memory operation as presented by the execute stage.
    typedef struct packed {
        logic                we;
        logic [A_WIDTH-1:0]  addr;
        logic [D_WIDTH-1:0]  wdata;
        logic [RD_WIDTH-1:0] rd;
    } lsu_req_t;

    // What the queue head is doing this cycle; recomputed every cycle, never stored.
    typedef enum logic [1:0] {
        LSU_IDLE     = 2'd0,
        LSU_ISSUE_ST = 2'd1,
        LSU_ISSUE_LD = 2'd2,
        LSU_STALL    = 2'd3
    } lsu_state_e;

    function automatic logic is_pow2(input int unsigned v);
        return (v != 0) && ((v & (v - 1)) == 0);
    endfunction

endpackage

// File: rtl/dmem_lsu_fifo.sv
// Synchronous request FIFO; head entry is visible combinationally.
module dmem_lsu_fifo
    import pico_pkg::*;
#(
    parameter  int unsigned DEPTH = 2,
    localparam int unsigned PTR_W = $clog2(DEPTH),
    localparam int unsigned CNT_W = PTR_W + 1
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             push,
    input  lsu_req_t         din,
    input  logic             pop,
    output lsu_req_t         head,
    output logic             full,
    output logic             empty,
    output logic [CNT_W-1:0] count
);

    lsu_req_t         mem [DEPTH];
    logic [PTR_W-1:0] wr_ptr;
    logic [PTR_W-1:0] rd_ptr;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign full    = (count == CNT_W'(DEPTH));
    assign empty   = (count == '0);
    assign head    = mem[rd_ptr];

    // Storage array; contents are don't-care while the entry is not counted.
    always_ff @(posedge clk) begin
        if (do_push) begin
            mem[wr_ptr] <= din;
        end
    end

    // Pointers wrap naturally because DEPTH is a power of two.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PTR_W'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PTR_W'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CNT_W'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CNT_W'(1);
            end
        end
    end

endmodule

// File: rtl/dmem_lsu.sv
// Load/store initiator for the 8-bit data memory.
// Queues in-order requests, issues the head to dmem one per cycle and
// returns load data through a one-entry response register.
// Optional: DMEM_LSU_BOUNDS_CHK_EN squashes accesses at or above DMEM_LIMIT.
module dmem_lsu
    import pico_pkg::*;
#(
    parameter int unsigned Q_DEPTH    = 2,
    parameter int unsigned DMEM_LIMIT = 256
) (
    input  logic                clk,
    input  logic                reset,
    input  logic                req_valid,
    output logic                req_ready,
    input  logic                req_we,
    input  logic [A_WIDTH-1:0]  req_addr,
    input  logic [D_WIDTH-1:0]  req_wdata,
    input  logic [RD_WIDTH-1:0] req_rd,
    output logic                rsp_valid,
    input  logic                rsp_ready,
    output logic [D_WIDTH-1:0]  rsp_rdata,
    output logic [RD_WIDTH-1:0] rsp_rd,
    output logic                rsp_err,
    output logic [A_WIDTH-1:0]  dmem_alu_result,
    output logic [D_WIDTH-1:0]  dmem_in,
    output logic                dmem_write_en,
    input  logic [D_WIDTH-1:0]  dmem_out,
    output logic                busy
);

    localparam int unsigned CNT_W = $clog2(Q_DEPTH) + 1;

    if (!is_pow2(Q_DEPTH) || (Q_DEPTH < 2)) begin : g_bad_depth
        $error("dmem_lsu: Q_DEPTH must be a power of two and at least 2");
    end
    if ((DMEM_LIMIT == 0) || (DMEM_LIMIT > (32'd1 << A_WIDTH))) begin : g_bad_limit
        $error("dmem_lsu: DMEM_LIMIT must lie in 1 .. 2**A_WIDTH");
    end

    lsu_req_t         push_req;
    lsu_req_t         head;
    logic             q_full;
    logic             q_empty;
    logic [CNT_W-1:0] q_count;
    logic             push;
    logic             pop;
    logic             slot_free;
    logic             oob;
    lsu_state_e       state;

    assign push_req = '{we: req_we, addr: req_addr, wdata: req_wdata, rd: req_rd};
    assign push     = req_valid && req_ready;

    dmem_lsu_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (push),
        .din   (push_req),
        .pop   (pop),
        .head  (head),
        .full  (q_full),
        .empty (q_empty),
        .count (q_count)
    );

`ifdef DMEM_LSU_BOUNDS_CHK_EN
    assign oob = (32'(head.addr) >= DMEM_LIMIT);
`else
    assign oob = 1'b0;
`endif

    // A load may only leave the queue when the response register is free or being drained.
    assign slot_free = !rsp_valid || rsp_ready;

    // Classify the head for this cycle.
    always_comb begin
        state = LSU_IDLE;
        if (!q_empty) begin
            if (head.we) begin
                state = LSU_ISSUE_ST;
            end else if (slot_free) begin
                state = LSU_ISSUE_LD;
            end else begin
                state = LSU_STALL;
            end
        end
    end

    assign pop             = (state == LSU_ISSUE_ST) || (state == LSU_ISSUE_LD);
    assign req_ready       = !q_full;
    assign busy            = (q_count != '0) || rsp_valid;
    assign dmem_alu_result = q_empty ? '0 : head.addr;
    assign dmem_in         = q_empty ? '0 : head.wdata;
    assign dmem_write_en   = (state == LSU_ISSUE_ST) && !oob;

    // Response register: captures dmem_out on the issuing edge and holds until accepted.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            rsp_valid <= 1'b0;
            rsp_rdata <= '0;
            rsp_rd    <= '0;
            rsp_err   <= 1'b0;
        end else if (state == LSU_ISSUE_LD) begin
            rsp_valid <= 1'b1;
            rsp_rdata <= oob ? '0 : dmem_out;
            rsp_rd    <= head.rd;
            rsp_err   <= oob;
        end else if (rsp_ready) begin
            rsp_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_dmem_lsu.sv
// Scoreboard bench for dmem_lsu: directed scenarios plus randomized traffic
// against an in-order memory model. Honours DMEM_LSU_BOUNDS_CHK_EN.
module tb_dmem_lsu;
    import pico_pkg::*;

`ifdef DMEM_LSU_BOUNDS_CHK_EN
    localparam int unsigned LIMIT = 128;
    localparam bit          BCHK  = 1'b1;
`else
    localparam int unsigned LIMIT = 256;
    localparam bit          BCHK  = 1'b0;
`endif

    typedef struct packed {
        logic       err;
        logic [2:0] rd;
        logic [7:0] rdata;
    } exp_t;

    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic       req_valid;
    logic       req_ready;
    logic       req_we;
    logic [7:0] req_addr;
    logic [7:0] req_wdata;
    logic [2:0] req_rd;
    logic       rsp_valid;
    logic       rsp_ready;
    logic [7:0] rsp_rdata;
    logic [2:0] rsp_rd;
    logic       rsp_err;
    logic [7:0] dmem_alu_result;
    logic [7:0] dmem_in;
    logic       dmem_write_en;
    logic [7:0] dmem_out;
    logic       busy;

    logic [7:0] env_mem [256];
    logic       init_done = 1'b0;
    logic [7:0] ref_mem [256];
    exp_t       sb [$];
    int         n_vec = 0;
    int         n_err = 0;

    always #5 clk = ~clk;

    dmem_lsu #(
        .Q_DEPTH    (2),
        .DMEM_LIMIT (LIMIT)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req_valid       (req_valid),
        .req_ready       (req_ready),
        .req_we          (req_we),
        .req_addr        (req_addr),
        .req_wdata       (req_wdata),
        .req_rd          (req_rd),
        .rsp_valid       (rsp_valid),
        .rsp_ready       (rsp_ready),
        .rsp_rdata       (rsp_rdata),
        .rsp_rd          (rsp_rd),
        .rsp_err         (rsp_err),
        .dmem_alu_result (dmem_alu_result),
        .dmem_in         (dmem_in),
        .dmem_write_en   (dmem_write_en),
        .dmem_out        (dmem_out),
        .busy            (busy)
    );

    function automatic logic [7:0] mem_init_val(input int i);
        return 8'((i * 37) + 11);
    endfunction

    // Data memory: async read, write on posedge.
    always @(posedge clk) begin
        if (!init_done) begin
            for (int i = 0; i < 256; i++) env_mem[i] <= mem_init_val(i);
            init_done <= 1'b1;
        end else if (dmem_write_en) begin
            env_mem[dmem_alu_result] <= dmem_in;
        end
    end
    assign dmem_out = env_mem[dmem_alu_result];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // Reference model: memory semantics applied in request order at acceptance time.
    task automatic model_accept(input logic we, input logic [7:0] addr,
                                input logic [7:0] wdata, input logic [2:0] rd);
        bit   bad;
        exp_t e;
        bad = BCHK && (int'(addr) >= int'(LIMIT));
        if (we) begin
            if (!bad) ref_mem[addr] = wdata;
        end else begin
            e.err   = bad;
            e.rd    = rd;
            e.rdata = bad ? 8'h00 : ref_mem[addr];
            sb.push_back(e);
        end
    endtask

    // Called at posedge+1; returns at posedge+1 after the accepting edge.
    task automatic push_op(input logic we, input logic [7:0] addr, input logic [7:0] wdata,
                           input logic [2:0] rd, input bit rnd, output int waited);
        waited    = 0;
        req_valid = 1'b1;
        req_we    = we;
        req_addr  = addr;
        req_wdata = wdata;
        req_rd    = rd;
        while (!req_ready && waited < 60) begin
            @(posedge clk); #1;
            waited++;
            if (rnd) rsp_ready = ($urandom_range(0, 3) != 0);
        end
        if (!req_ready) begin
            n_vec++;
            n_err++;
            $display("FAIL push_timeout: req_ready stayed 0 for %0d cycles, expected 1", waited);
            req_valid = 1'b0;
            return;
        end
        model_accept(we, addr, wdata, rd);
        @(posedge clk); #1;
        req_valid = 1'b0;
    endtask

    // Monitor: pops the scoreboard on every response handshake and checks hold stability.
    initial begin : monitor
        logic        hold;
        logic [11:0] hv;
        exp_t        e;
        hold = 1'b0;
        hv   = '0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                hold = 1'b0;
            end else begin
                if (hold)
                    check("rsp_hold", 32'({rsp_valid, rsp_err, rsp_rd, rsp_rdata}), 32'({1'b1, hv}));
                if (rsp_valid && rsp_ready) begin
                    if (sb.size() == 0) begin
                        n_vec++;
                        n_err++;
                        $display("FAIL rsp_unexpected: got rd=%0d data=0x%0h, expected no response",
                                 rsp_rd, rsp_rdata);
                    end else begin
                        e = sb.pop_front();
                        check("rsp_data", 32'({rsp_err, rsp_rd, rsp_rdata}), 32'(e));
                    end
                end
                hold = rsp_valid && !rsp_ready;
                hv   = {rsp_err, rsp_rd, rsp_rdata};
            end
        end
    end

    initial begin : stim
        int         w;
        int         bad_waits;
        logic [7:0] old_val;
        logic [7:0] a;
        req_valid = 1'b0;
        req_we    = 1'b0;
        req_addr  = '0;
        req_wdata = '0;
        req_rd    = '0;
        rsp_ready = 1'b1;
        for (int i = 0; i < 256; i++) ref_mem[i] = mem_init_val(i);

        // Reset values
        repeat (3) @(posedge clk);
        #1;
        check("rst_rsp_valid", 32'(rsp_valid), 32'(0));
        check("rst_rsp_rdata", 32'(rsp_rdata), 32'(0));
        check("rst_rsp_rd", 32'(rsp_rd), 32'(0));
        check("rst_rsp_err", 32'(rsp_err), 32'(0));
        check("rst_busy", 32'(busy), 32'(0));
        check("rst_write_en", 32'(dmem_write_en), 32'(0));
        reset = 1'b1;
        @(posedge clk); #1;
        check("rst_req_ready", 32'(req_ready), 32'(1));
        check("idle_addr", 32'(dmem_alu_result), 32'(0));

        // Store 0x5A to 0x10, then load it back
        push_op(1'b1, 8'h10, 8'h5A, 3'd0, 1'b0, w);
        check("st_write_en", 32'(dmem_write_en), 32'(1));
        check("st_addr", 32'(dmem_alu_result), 32'h10);
        check("st_wdata", 32'(dmem_in), 32'h5A);
        push_op(1'b0, 8'h10, 8'h00, 3'd3, 1'b0, w);
        check("ld_no_write", 32'(dmem_write_en), 32'(0));
        check("ld_addr", 32'(dmem_alu_result), 32'h10);
        check("ld_lat_early", 32'(rsp_valid), 32'(0));
        @(posedge clk); #1;
        check("ld_lat_valid", 32'(rsp_valid), 32'(1));
        check("ld_lat_data", 32'({rsp_rd, rsp_rdata}), 32'({3'd3, 8'h5A}));
        check("st_mem", 32'(env_mem[8'h10]), 32'h5A);
        @(posedge clk); #1;
        check("idle_busy", 32'(busy), 32'(0));

        // Three loads with the consumer stalled
        rsp_ready = 1'b0;
        push_op(1'b0, 8'h20, 8'h00, 3'd1, 1'b0, w);
        push_op(1'b0, 8'h21, 8'h00, 3'd2, 1'b0, w);
        push_op(1'b0, 8'h22, 8'h00, 3'd3, 1'b0, w);
        check("full_ready", 32'(req_ready), 32'(0));
        check("full_busy", 32'(busy), 32'(1));
        check("stall_no_write", 32'(dmem_write_en), 32'(0));
        repeat (5) begin @(posedge clk); #1; end
        check("stall_rd", 32'({rsp_valid, rsp_rd}), 32'({1'b1, 3'd1}));
        rsp_ready = 1'b1;
        @(posedge clk); #1;
        check("b2b_first", 32'({rsp_valid, rsp_rd}), 32'({1'b1, 3'd2}));
        @(posedge clk); #1;
        check("b2b_second", 32'({rsp_valid, rsp_rd}), 32'({1'b1, 3'd3}));
        @(posedge clk); #1;
        check("b2b_done", 32'(rsp_valid), 32'(0));

        // Alternating store/load at the address extremes, one op per cycle
        bad_waits = 0;
        for (int i = 0; i < 12; i++) begin
            a = (((i / 2) % 2) == 1) ? 8'h00 : 8'hFF;
            push_op((i % 2) == 0, a, 8'($urandom_range(0, 255)), 3'(i % 8), 1'b0, w);
            bad_waits += w;
        end
        check("one_per_cycle", 32'(bad_waits), 32'(0));
        repeat (4) begin @(posedge clk); #1; end

        // Asynchronous reset while a store is at the head
        old_val = ref_mem[8'h33];
        push_op(1'b1, 8'h33, ~old_val, 3'd0, 1'b0, w);
        check("rst_st_pending", 32'(dmem_write_en), 32'(1));
        #2;
        reset = 1'b0;
        #1;
        check("rst_async_we", 32'(dmem_write_en), 32'(0));
        check("rst_async_busy", 32'(busy), 32'(0));
        sb.delete();
        ref_mem[8'h33] = old_val;
        @(posedge clk); #1;
        reset = 1'b1;
        check("rst_mem_kept", 32'(env_mem[8'h33]), 32'(old_val));
        push_op(1'b0, 8'h33, 8'h00, 3'd6, 1'b0, w);
        repeat (3) begin @(posedge clk); #1; end

`ifdef DMEM_LSU_BOUNDS_CHK_EN
        // Out-of-range accesses are squashed
        push_op(1'b1, 8'h80, 8'h99, 3'd0, 1'b0, w);
        check("oob_st_we", 32'(dmem_write_en), 32'(0));
        check("oob_st_addr", 32'(dmem_alu_result), 32'h80);
        push_op(1'b0, 8'h80, 8'h00, 3'd5, 1'b0, w);
        @(posedge clk); #1;
        check("oob_ld_rsp", 32'({rsp_valid, rsp_err, rsp_rdata}), 32'({1'b1, 1'b1, 8'h00}));
        push_op(1'b0, 8'h7F, 8'h00, 3'd4, 1'b0, w);
        repeat (3) begin @(posedge clk); #1; end
`endif

        // Randomized traffic with a randomly stalling consumer
        for (int i = 0; i < 300; i++) begin
            rsp_ready = ($urandom_range(0, 3) != 0);
            if ($urandom_range(0, 3) == 0) begin
                @(posedge clk); #1;
            end else begin
                if ($urandom_range(0, 1) == 1) a = 8'(8'h10 + 8'($urandom_range(0, 3)));
                else                           a = 8'($urandom_range(0, 255));
                push_op($urandom_range(0, 1) == 1, a, 8'($urandom_range(0, 255)),
                        3'($urandom_range(0, 7)), 1'b1, w);
            end
        end

        // Drain
        rsp_ready = 1'b1;
        for (int i = 0; i < 200 && busy; i++) begin @(posedge clk); #1; end
        check("drain_busy", 32'(busy), 32'(0));
        check("drain_sb_empty", 32'(sb.size()), 32'(0));

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
